// File: rtl/cnu_serial_minsum.sv
// Serial-I/O min-sum check node: collects DC edge messages per frame, emits DC
// check-to-variable messages from a second bank. Optional offset: CNU_OFFSET_EN.
module cnu_serial_minsum #(
    parameter int unsigned DC     = 6,
    parameter int unsigned MAG_W  = 4,
    parameter int unsigned OFFSET = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [MAG_W+1:0]       in_msg,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [MAG_W:0]         out_msg,
    output logic [$clog2(DC)-1:0]  out_idx,
    output logic                   p_bit
);

    localparam int unsigned       IDX_W   = $clog2(DC);
    localparam logic [IDX_W-1:0]  LAST    = IDX_W'(DC - 1);
    localparam logic [MAG_W-1:0]  MAG_MAX = '1;
`ifdef CNU_OFFSET_EN
    localparam int unsigned       OFFSET_EN = 1;
`else
    localparam int unsigned       OFFSET_EN = 0;
`endif
    localparam int unsigned       OFF_AMT = OFFSET * OFFSET_EN;

    typedef enum logic {OB_IDLE, OB_BUSY} ob_state_e;

    function automatic logic [MAG_W-1:0] apply_offset(input logic [MAG_W-1:0] m);
        logic [MAG_W:0] diff;
        diff = {1'b0, m} - (MAG_W+1)'(OFF_AMT);
        return diff[MAG_W] ? '0 : diff[MAG_W-1:0];
    endfunction

    // collect bank
    logic [IDX_W-1:0] in_cnt_q, in_cnt_d;
    logic [MAG_W-1:0] min1_q, min1_d, min2_q, min2_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             sxor_q, sxor_d, par_q, par_d;
    logic [DC-1:0]    sign_q, sign_d;

    // output bank
    ob_state_e        ob_state_q, ob_state_d;
    logic [MAG_W-1:0] ob_min1_q, ob_min1_d, ob_min2_q, ob_min2_d;
    logic [IDX_W-1:0] ob_idx_q, ob_idx_d;
    logic             ob_sxor_q, ob_sxor_d;
    logic [DC-1:0]    ob_sign_q, ob_sign_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic             p_bit_q, p_bit_d;

    logic             busy, last_hs, accept, close;
    logic [MAG_W-1:0] mag;
    logic [MAG_W-1:0] upd_min1, upd_min2;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_sxor, upd_par;
    logic [DC-1:0]    upd_sign;

    assign busy     = (ob_state_q == OB_BUSY);
    assign last_hs  = busy && out_ready && (out_idx_q == LAST);
    // only the frame-closing edge can stall, and only if the bank won't free this cycle
    assign in_ready = !((in_cnt_q == LAST) && busy && !last_hs);
    assign accept   = in_valid && in_ready;
    assign close    = accept && (in_cnt_q == LAST);
    assign mag      = in_msg[MAG_W-1:0];

    always_comb begin
        upd_min1 = min1_q;
        upd_min2 = min2_q;
        upd_idx  = idx_q;
        if (mag < min1_q) begin
            upd_min2 = min1_q;
            upd_min1 = mag;
            upd_idx  = in_cnt_q;
        end else if (mag < min2_q) begin
            upd_min2 = mag;
        end
        upd_sxor           = sxor_q ^ in_msg[MAG_W];
        upd_par            = par_q ^ in_msg[MAG_W+1];
        upd_sign           = sign_q;
        upd_sign[in_cnt_q] = in_msg[MAG_W];
    end

    always_comb begin
        in_cnt_d   = in_cnt_q;
        min1_d     = min1_q;
        min2_d     = min2_q;
        idx_d      = idx_q;
        sxor_d     = sxor_q;
        par_d      = par_q;
        sign_d     = sign_q;
        ob_state_d = ob_state_q;
        ob_min1_d  = ob_min1_q;
        ob_min2_d  = ob_min2_q;
        ob_idx_d   = ob_idx_q;
        ob_sxor_d  = ob_sxor_q;
        ob_sign_d  = ob_sign_q;
        out_idx_d  = out_idx_q;
        p_bit_d    = p_bit_q;

        if (close) begin
            in_cnt_d  = '0;
            min1_d    = MAG_MAX;
            min2_d    = MAG_MAX;
            idx_d     = '0;
            sxor_d    = 1'b0;
            par_d     = 1'b0;
            sign_d    = '0;
            ob_min1_d = apply_offset(upd_min1);
            ob_min2_d = apply_offset(upd_min2);
            ob_idx_d  = upd_idx;
            ob_sxor_d = upd_sxor;
            ob_sign_d = upd_sign;
            p_bit_d   = upd_par;
        end else if (accept) begin
            in_cnt_d = in_cnt_q + 1'b1;
            min1_d   = upd_min1;
            min2_d   = upd_min2;
            idx_d    = upd_idx;
            sxor_d   = upd_sxor;
            par_d    = upd_par;
            sign_d   = upd_sign;
        end

        // a close coinciding with the last handshake reloads without a bubble
        if (close) begin
            ob_state_d = OB_BUSY;
            out_idx_d  = '0;
        end else if (busy && out_ready) begin
            if (out_idx_q == LAST) begin
                ob_state_d = OB_IDLE;
                out_idx_d  = '0;
            end else begin
                out_idx_d = out_idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt_q   <= '0;
            min1_q     <= MAG_MAX;
            min2_q     <= MAG_MAX;
            idx_q      <= '0;
            sxor_q     <= 1'b0;
            par_q      <= 1'b0;
            sign_q     <= '0;
            ob_state_q <= OB_IDLE;
            ob_min1_q  <= '0;
            ob_min2_q  <= '0;
            ob_idx_q   <= '0;
            ob_sxor_q  <= 1'b0;
            ob_sign_q  <= '0;
            out_idx_q  <= '0;
            p_bit_q    <= 1'b0;
        end else begin
            in_cnt_q   <= in_cnt_d;
            min1_q     <= min1_d;
            min2_q     <= min2_d;
            idx_q      <= idx_d;
            sxor_q     <= sxor_d;
            par_q      <= par_d;
            sign_q     <= sign_d;
            ob_state_q <= ob_state_d;
            ob_min1_q  <= ob_min1_d;
            ob_min2_q  <= ob_min2_d;
            ob_idx_q   <= ob_idx_d;
            ob_sxor_q  <= ob_sxor_d;
            ob_sign_q  <= ob_sign_d;
            out_idx_q  <= out_idx_d;
            p_bit_q    <= p_bit_d;
        end
    end

    assign out_valid = busy;
    assign out_idx   = out_idx_q;
    assign p_bit     = p_bit_q;
    assign out_msg   = busy ? {ob_sxor_q ^ ob_sign_q[out_idx_q],
                               (out_idx_q == ob_idx_q) ? ob_min2_q : ob_min1_q}
                            : '0;

endmodule

// File: tb/tb_cnu_serial_minsum.sv
// Directed bench for cnu_serial_minsum (DC=6, MAG_W=4, OFFSET=1); expectations
// follow CNU_OFFSET_EN when it is defined for the build.
module tb_cnu_serial_minsum;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] in_msg;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_msg;
    logic [2:0] out_idx;
    logic       p_bit;

    always #5 clk = ~clk;

    cnu_serial_minsum #(.DC(6), .MAG_W(4), .OFFSET(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_msg    (in_msg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_msg   (out_msg),
        .out_idx   (out_idx),
        .p_bit     (p_bit)
    );

    // element [k] of every packed array is edge k
    typedef struct packed {
        logic [5:0][3:0] mag;
        logic [5:0]      sgn;
        logic [5:0]      hd;
        logic [5:0][3:0] emag;
        logic [5:0]      esgn;
        logic            ep;
    } vec_t;

    vec_t tv [5];
    int   ov_list [3];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] offm(input logic [3:0] m);
`ifdef CNU_OFFSET_EN
        return (m > 4'd1) ? m - 4'd1 : 4'd0;
`else
        return m;
`endif
    endfunction

    function automatic logic [4:0] emsg(input int f, input int k);
        return {tv[f].esgn[k], offm(tv[f].emag[k])};
    endfunction

    // entered and left just after a falling edge
    task automatic send_edge(input int f, input int k);
        int w;
        w = 0;
        in_valid = 1'b1;
        in_msg   = {tv[f].hd[k], tv[f].sgn[k], tv[f].mag[k]};
        while (!in_ready && w < 40) begin
            @(posedge clk); @(negedge clk);
            w++;
        end
        if (w >= 40) begin
            n_chk++; n_fail++;
            $display("FAIL send_timeout: in_ready stuck at 0 frame %0d edge %0d", f, k);
        end
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int f);
        for (int k = 0; k < 6; k++) send_edge(f, k);
    endtask

    // one cycle after close: output frame open at index 0, parity updated
    task automatic chk_open(input int f);
        chk($sformatf("open_valid_f%0d", f), out_valid, 1);
        chk($sformatf("open_idx_f%0d", f), out_idx, 0);
        chk($sformatf("p_bit_f%0d", f), p_bit, tv[f].ep);
    endtask

    task automatic recv_frame(input int f);
        int w;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            w = 0;
            while (!out_valid && w < 40) begin
                @(posedge clk); @(negedge clk);
                w++;
            end
            if (w >= 40) begin
                n_chk++; n_fail++;
                $display("FAIL recv_timeout: out_valid stuck at 0 frame %0d edge %0d", f, k);
            end
            chk($sformatf("out_idx_f%0d_e%0d", f, k), out_idx, k);
            chk($sformatf("out_msg_f%0d_e%0d", f, k), out_msg, emsg(f, k));
            @(posedge clk); @(negedge clk);
        end
        chk($sformatf("drained_f%0d", f), out_valid, 0);
        out_ready = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tv[0].mag  = {4'd12, 4'd9, 4'd3, 4'd7, 4'd2, 4'd5};
        tv[0].sgn  = 6'b010010;
        tv[0].hd   = 6'b001101;
        tv[0].emag = {4'd2, 4'd2, 4'd2, 4'd2, 4'd3, 4'd2};
        tv[0].esgn = 6'b010010;
        tv[0].ep   = 1'b1;

        tv[1].mag  = '0;
        tv[1].sgn  = 6'b000111;
        tv[1].hd   = 6'b111111;
        tv[1].emag = '0;
        tv[1].esgn = 6'b111000;
        tv[1].ep   = 1'b0;

        tv[2].mag  = {4'd9, 4'd9, 4'd9, 4'd9, 4'd4, 4'd4};
        tv[2].sgn  = 6'b000001;
        tv[2].hd   = 6'b000011;
        tv[2].emag = {4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4};
        tv[2].esgn = 6'b111110;
        tv[2].ep   = 1'b0;

        tv[3].mag  = {4'd14, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
        tv[3].sgn  = 6'b000000;
        tv[3].hd   = 6'b100000;
        tv[3].emag = {4'd15, 4'd14, 4'd14, 4'd14, 4'd14, 4'd14};
        tv[3].esgn = 6'b000000;
        tv[3].ep   = 1'b1;

        tv[4].mag  = {4'd7, 4'd3, 4'd0, 4'd6, 4'd1, 4'd8};
        tv[4].sgn  = 6'b001011;
        tv[4].hd   = 6'b000000;
        tv[4].emag = {4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0};
        tv[4].esgn = 6'b110100;
        tv[4].ep   = 1'b0;

        ov_list = '{0, 2, 3};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_msg = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_msg", out_msg, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_p_bit", p_bit, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int f = 0; f < 5; f++) begin
            send_frame(f);
            chk_open(f);
            recv_frame(f);
        end

        // back-pressure: frame 0 held, frame 4 edges 0..4 accepted, edge 5 stalls
        out_ready = 1'b0;
        send_frame(0);
        chk_open(0);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_ready_e%0d", k), in_ready, 1);
            send_edge(4, k);
        end
        in_valid = 1'b1;
        in_msg   = {tv[4].hd[5], tv[4].sgn[5], tv[4].mag[5]};
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("bp_stall_ready_c%0d", c), in_ready, 0);
            chk($sformatf("bp_hold_idx_c%0d", c), out_idx, 0);
            chk($sformatf("bp_hold_msg_c%0d", c), out_msg, emsg(0, 0));
            @(posedge clk); @(negedge clk);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("bp_rel_idx_e%0d", k), out_idx, k);
            chk($sformatf("bp_rel_msg_e%0d", k), out_msg, emsg(0, k));
            chk($sformatf("bp_rel_ready_e%0d", k), in_ready, (k == 5) ? 1 : 0);
            @(posedge clk); @(negedge clk);
        end
        in_valid = 1'b0;
        chk_open(4);
        recv_frame(4);

        // overlap: continuous input, out_ready held high
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    for (int k = 0; k < 6; k++) begin
                        chk($sformatf("ov_ready_f%0d_e%0d", ov_list[i], k), in_ready, 1);
                        send_edge(ov_list[i], k);
                    end
                end
            end
            begin
                int w;
                w = 0;
                while (!out_valid && w < 40) begin
                    @(negedge clk);
                    w++;
                end
                if (w >= 40) begin
                    n_chk++; n_fail++;
                    $display("FAIL ov_timeout: out_valid never rose");
                end
                for (int j = 0; j < 18; j++) begin
                    chk($sformatf("ov_valid_j%0d", j), out_valid, 1);
                    chk($sformatf("ov_idx_j%0d", j), out_idx, j % 6);
                    chk($sformatf("ov_msg_j%0d", j), out_msg, emsg(ov_list[j / 6], j % 6));
                    if (j % 6 == 0) chk($sformatf("ov_p_bit_j%0d", j), p_bit, tv[ov_list[j / 6]].ep);
                    @(posedge clk); @(negedge clk);
                end
                chk("ov_drained", out_valid, 0);
            end
        join
        out_ready = 1'b0;

        // reset with output pending and a partial collect frame
        send_frame(0);
        chk_open(0);
        for (int k = 0; k < 3; k++) send_edge(4, k);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_msg", out_msg, 0);
        chk("mid_rst_out_idx", out_idx, 0);
        chk("mid_rst_p_bit", p_bit, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(3);
        chk_open(3);
        recv_frame(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
